change_dispenser: RTL
=====================

# change_dispenser

Sequencing controller for the vending machine's coin-return hopper. When the vending FSM computes change after delivery, it hands the amount to this block. The block then ejects coins one at a time, greedy largest-first (5 zł, 2 zł, 1 zł), handshaking each coin with the hopper. It also tracks per-denomination stock and flags change that cannot be paid.

## Interface
Parameters:
- AMT_W, 8, width of amount and remaining (zł units)
- INV_W, 6, width of each stock counter
- STOCK_INIT, 4, coins per denomination loaded at reset and refill
- ACK_TIMEOUT, 255, cycles to wait in WAIT_ACK before giving up

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; sampled on rising clk edge
- start  in  1  request pulse; accepted only in IDLE
- amount  in  AMT_W  change to pay; latched when start is accepted
- eject_ack  in  1  hopper confirms one coin released
- refill  in  1  reloads all three stock counters to STOCK_INIT
- eject  out  3  one-hot coin command, one cycle wide: bit0 = 1 zł, bit1 = 2 zł, bit2 = 5 zł (same encoding as the coin input)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in DONE
- error  out  1  change not fully paid; held until the next accepted start
- remaining  out  AMT_W  amount still owed
- stock_empty  out  3  per-denomination stock == 0, same bit order as eject

## Operation
- State machine with five states: IDLE, PICK, EJECT, WAIT_ACK, DONE.
- IDLE
  - start=1: latch remaining <= amount, clear error, go to PICK.
  - start=0: stay in IDLE.
- PICK (one cycle), first matching rule wins:
  - remaining == 0: go to DONE.
  - remaining >= 5 and stock5 > 0: coin = 5.
  - remaining >= 2 and stock2 > 0: coin = 2.
  - remaining >= 1 and stock1 > 0: coin = 1.
  - Otherwise: set error=1 and go to DONE.
  - When a coin is chosen, register it and go to EJECT.
- EJECT: drive eject = one-hot of the coin for exactly this cycle, clear the timeout counter, go to WAIT_ACK.
- WAIT_ACK
  - eject_ack=1: remaining -= coin value, decrement that coin's stock, go to PICK.
  - Timeout counter reaches ACK_TIMEOUT-1 without an ack: set error=1, leave remaining and stock unchanged, go to DONE.
- DONE: done=1, go to IDLE.
- Ignored inputs:
  - eject_ack outside WAIT_ACK.
  - start outside IDLE.
- Arithmetic:
  - remaining never underflows, because PICK only selects coins <= remaining.
  - Stock counters are unsigned INV_W bits and never decrement at 0, because PICK requires stock > 0.
- refill is accepted in any state. If refill and an ack decrement hit the same cycle, refill wins (stock = STOCK_INIT).
- stock_empty is combinational from the stock registers.

## Timing
- Reset values: state IDLE, eject=000, busy=0, done=0, error=0, remaining=0, all stocks = STOCK_INIT, stock_empty=000.
- Reset mid-operation aborts immediately. A coin already commanded is not accounted for.
- busy rises in the cycle after start is accepted.
- Each coin costs at least 3 cycles (PICK, EJECT, WAIT_ACK), with the ack arriving in the first WAIT_ACK cycle.
- For n coins with immediate acks, done is high 3n+2 cycles after the start cycle. Example: amount 3 gives done at cycle 8, back in IDLE at cycle 9.
- amount 0: done at cycle 2, no eject.
- Timeout: the error path exits WAIT_ACK after ACK_TIMEOUT cycles.
- remaining and stock update on the clock edge that samples eject_ack. The new values are visible in the following PICK.
- The eject one-hot is never multi-bit and is never asserted for two consecutive cycles.

## Test plan
- Full stock (4/4/4): reset, then start with amount 8, ack in the first WAIT_ACK cycle each time.
  - Required: eject sequence 100, 010, 001.
  - Required: done at cycle 11, error=0, remaining=0, stocks 3/3/3.
- STOCK_INIT=1, amount 4:
  - Required: eject 010, then 001, then PICK finds no coin.
  - Required: error=1, remaining=1, stock_empty=011.
- amount 5 with eject_ack held low:
  - Required: a single 100 pulse, then done after ACK_TIMEOUT cycles in WAIT_ACK.
  - Required: error=1, remaining=5, stock5 still 4.
- amount 0:
  - Required: done at cycle 2, eject never asserted, error=0.
- Contention inputs during an amount-7 run:
  - start pulsed while busy: ignored, remaining unaffected.
  - refill in the same cycle as the first ack: stock5 = 4 afterwards (not 3); the run still completes 5 then 2.
- reset asserted in WAIT_ACK:
  - Required: on the next cycle, state is IDLE and all outputs hold their reset values.
  - Required: a new start with amount 2 then completes normally.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: coin-return hopper sequencer.
// Pays an amount greedily (5, 2, 1 zl) one coin at a time, handshaking each
// coin with the hopper, tracking per-denomination stock and flagging change
// that cannot be paid (out of stock or hopper never acknowledged).
module change_dispenser #(
  parameter int AMT_W       = 8,
  parameter int INV_W       = 6,
  parameter int STOCK_INIT  = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             eject_ack,
  input  logic             refill,
  output logic [2:0]       eject,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [AMT_W-1:0] remaining,
  output logic [2:0]       stock_empty
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [INV_W-1:0] SINIT   = INV_W'(STOCK_INIT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, PICK, EJECT, WAIT_ACK, DONE} state_t;

  state_t           state_q;
  logic [2:0]       coin_q;    // one-hot coin in flight, same encoding as eject
  logic [2:0]       eject_q;
  logic             done_q;
  logic             error_q;
  logic [AMT_W-1:0] rem_q;
  logic [INV_W-1:0] s1_q, s2_q, s5_q;
  logic [CNT_W-1:0] cnt_q;

  // Value in zl of a one-hot coin code.
  function automatic logic [AMT_W-1:0] coin_val(input logic [2:0] c);
    case (c)
      3'b100:  coin_val = AMT_W'(5);
      3'b010:  coin_val = AMT_W'(2);
      3'b001:  coin_val = AMT_W'(1);
      default: coin_val = '0;
    endcase
  endfunction

  // Greedy choice of the largest coin that fits and is in stock (000 = none).
  logic [2:0] pick_coin;
  always_comb begin
    pick_coin = 3'b000;
    if (rem_q >= AMT_W'(5) && s5_q != '0)      pick_coin = 3'b100;
    else if (rem_q >= AMT_W'(2) && s2_q != '0) pick_coin = 3'b010;
    else if (rem_q >= AMT_W'(1) && s1_q != '0) pick_coin = 3'b001;
  end

  // Control FSM with registered outputs, remaining and stock accounting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      coin_q  <= '0;
      eject_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      rem_q   <= '0;
      s1_q    <= SINIT;
      s2_q    <= SINIT;
      s5_q    <= SINIT;
      cnt_q   <= '0;
    end else begin
      eject_q <= '0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          rem_q   <= amount;
          error_q <= 1'b0;
          state_q <= PICK;
        end
        PICK: begin
          if (rem_q == '0) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (pick_coin != 3'b000) begin
            coin_q  <= pick_coin;
            eject_q <= pick_coin;   // high during the EJECT cycle only
            state_q <= EJECT;
          end else begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        EJECT: begin
          cnt_q   <= '0;
          state_q <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (eject_ack) begin
            rem_q <= rem_q - coin_val(coin_q);
            if (coin_q[0]) s1_q <= s1_q - 1'b1;
            if (coin_q[1]) s2_q <= s2_q - 1'b1;
            if (coin_q[2]) s5_q <= s5_q - 1'b1;
            state_q <= PICK;
          end else if (cnt_q == TO_LAST) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      // Refill overrides any same-cycle decrement.
      if (refill) begin
        s1_q <= SINIT;
        s2_q <= SINIT;
        s5_q <= SINIT;
      end
    end
  end

  assign eject       = eject_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign error       = error_q;
  assign remaining   = rem_q;
  assign stock_empty = {s5_q == '0, s2_q == '0, s1_q == '0};

endmodule
